// File: rtl/bfp_dot_accum.sv
// Block-floating-point dot-product accumulator: lane-wise multiply of two
// mantissa streams, per-beat reduction, and accumulation over V/P beats.
// Emits the signed result and the combined block exponent as a one-cycle pulse.
module bfp_dot_accum #(
  parameter  int unsigned V    = 8,
  parameter  int unsigned P    = 2,
  parameter  int unsigned BIT  = 16,
  parameter  int unsigned FPM  = 10,
  parameter  int unsigned BFPM = 7,
  localparam int unsigned MW   = BFPM + 2,
  localparam int unsigned EW   = BIT - FPM - 1,
  localparam int unsigned PW   = 2 * MW,
  localparam int unsigned ACCW = PW + $clog2(V)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [P-1:0][MW-1:0]  a_mants,
  input  logic [EW-1:0]         a_exp,
  input  logic                  a_done,
  input  logic                  b_valid,
  input  logic [P-1:0][MW-1:0]  b_mants,
  input  logic [EW-1:0]         b_exp,
  input  logic                  b_done,
  output logic                  out_valid,
  output logic [ACCW-1:0]       out_mant,
  output logic [EW:0]           out_exp,
  output logic                  err
);

  localparam int unsigned NB  = V / P;
  localparam int unsigned CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned EXW = EW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, ERROR} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   acc_c, first_c, last_c, viol_c;
  logic [EXW-1:0]         exp_sum_c;

  logic                   s0_vld_q, s0_first_q, s0_last_q;
  logic [P-1:0][MW-1:0]   s0_a_q, s0_b_q;
  logic [EXW-1:0]         s0_exp_q;

  logic [P-1:0][PW-1:0]   prod_c;
  logic                   s1_vld_q, s1_first_q, s1_last_q;
  logic [P-1:0][PW-1:0]   s1_prod_q;
  logic [EXW-1:0]         s1_exp_q;

  logic signed [ACCW-1:0] sum_c;
  logic signed [ACCW-1:0] acc_q;
  logic [EXW-1:0]         acc_exp_q;
  logic                   s2_last_q;

  logic                   out_valid_q;
  logic [ACCW-1:0]        out_mant_q;
  logic [EXW-1:0]         out_exp_q;
  logic                   err_q;

  assign exp_sum_c = EXW'(a_exp) + EXW'(b_exp);

  // Beat-count FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, beat acceptance, first/last tagging and protocol checking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_c   = 1'b0;
    first_c = 1'b0;
    last_c  = 1'b0;
    viol_c  = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        // A done landing together with the last beat counts as an early done.
        viol_c = (a_valid != b_valid) || (a_done != b_done) ||
                 ((state_q == ACCUM) && (cnt_q != '0) && (a_done || b_done));
        if (viol_c) begin
          state_d = ERROR;
          cnt_d   = '0;
        end else if (a_valid && b_valid) begin
          acc_c   = 1'b1;
          first_c = (cnt_q == '0);
          last_c  = (cnt_q == CW'(NB - 1));
          if (last_c) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ACCUM;
          end
        end
      end
      ERROR: begin
        if (a_done && b_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // S0: capture accepted beat; the exponent sum is latched only on a first beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_vld_q   <= 1'b0;
      s0_first_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
      s0_exp_q   <= '0;
    end else begin
      s0_vld_q   <= acc_c;
      s0_first_q <= first_c;
      s0_last_q  <= last_c;
      if (acc_c) begin
        s0_a_q <= a_mants;
        s0_b_q <= b_mants;
      end
      if (first_c) s0_exp_q <= exp_sum_c;
    end
  end

  // Lane-wise signed products at full precision.
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < int'(P); i++) begin
      prod_c[i] = $signed(PW'($signed(s0_a_q[i]))) * $signed(PW'($signed(s0_b_q[i])));
    end
  end

  // S1: register products; the exponent travels with the beat so back-to-back
  // vectors cannot overwrite an exponent still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
      s1_exp_q   <= '0;
    end else begin
      s1_vld_q   <= s0_vld_q;
      s1_first_q <= s0_vld_q & s0_first_q;
      s1_last_q  <= s0_vld_q & s0_last_q;
      s1_prod_q  <= prod_c;
      s1_exp_q   <= s0_exp_q;
    end
  end

  // Sign-extended reduction of the lane products.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(P); i++) begin
      sum_c = sum_c + ACCW'($signed(s1_prod_q[i]));
    end
  end

  // S2: accumulator restarts on a first-tagged beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      acc_exp_q <= '0;
      s2_last_q <= 1'b0;
    end else begin
      s2_last_q <= s1_vld_q & s1_last_q;
      if (s1_vld_q) begin
        acc_q <= s1_first_q ? sum_c : acc_q + sum_c;
        if (s1_first_q) acc_exp_q <= s1_exp_q;
      end
    end
  end

  // Output stage: one-cycle result pulse; value holds until the next pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
    end else begin
      out_valid_q <= s2_last_q;
      if (s2_last_q) begin
        out_mant_q <= acc_q;
        out_exp_q  <= acc_exp_q;
      end
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | viol_c;
  end

  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bfp_dot_accum.sv
// Directed testbench for bfp_dot_accum (V=8, P=2, BFPM=7: 4 beats of 2 lanes).
module tb_bfp_dot_accum;

  localparam int unsigned MW   = 9;
  localparam int unsigned EW   = 5;
  localparam int unsigned ACCW = 21;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 a_valid, b_valid, a_done, b_done;
  logic [1:0][MW-1:0]   a_mants, b_mants;
  logic [EW-1:0]        a_exp, b_exp;
  logic                 out_valid;
  logic [ACCW-1:0]      out_mant;
  logic [EW:0]          out_exp;
  logic                 err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic signed [63:0] qm[$];
  int                 qe[$];
  int                 qc[$];

  bfp_dot_accum dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_mants   (a_mants),
    .a_exp     (a_exp),
    .a_done    (a_done),
    .b_valid   (b_valid),
    .b_mants   (b_mants),
    .b_exp     (b_exp),
    .b_done    (b_done),
    .out_valid (out_valid),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every result pulse with the clock-edge index it followed.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      qm.push_back($signed(out_mant));
      qe.push_back(int'(out_exp));
      qc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0; b_valid = 1'b0; a_done = 1'b0; b_done = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a0, input int a1, input int b0, input int b1,
                      input int ae, input int be,
                      input bit av = 1'b1, input bit bv = 1'b1);
    a_valid = av; b_valid = bv; a_done = 1'b0; b_done = 1'b0;
    a_mants[0] = MW'(a0); a_mants[1] = MW'(a1);
    b_mants[0] = MW'(b0); b_mants[1] = MW'(b1);
    a_exp = EW'(ae); b_exp = EW'(be);
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    a_valid = 1'b0; b_valid = 1'b0; a_done = 1'b1; b_done = 1'b1;
    @(posedge clk);
    #1;
    a_done = 1'b0; b_done = 1'b0;
  endtask

  // Non-first beats carry exponent 31 so any use of them corrupts out_exp.
  task automatic send_vec(input int a[8], input int b[8], input int ae,
                          input int be, output int last_cyc);
    for (int k = 0; k < 4; k++) begin
      beat(a[2*k], a[2*k+1], b[2*k], b[2*k+1], (k == 0) ? ae : 31,
           (k == 0) ? be : 31);
    end
    last_cyc = cyc;
  endtask

  task automatic expect_out(input string tag, input longint m, input int e,
                            output int c);
    c = 0;
    if (qm.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      chk({tag, "_mant"}, qm.pop_front(), m);
      chk({tag, "_exp"}, qe.pop_front(), e);
      c = qc.pop_front();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int va[8], vb[8];
    int lc, lc2, c1, c2;

    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_done = 1'b0; b_done = 1'b0;
    a_mants = '0; b_mants = '0; a_exp = '0; b_exp = '0;
    #23;
    chk("rst_valid", out_valid, 0);
    chk("rst_mant", $signed(out_mant), 0);
    chk("rst_exp", out_exp, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic vector: 8 x (128*128) = 131072, exponent 15+15.
    va = '{128, 128, 128, 128, 128, 128, 128, 128};
    vb = va;
    send_vec(va, vb, 15, 15, lc);
    idle(6);
    chk("t1_npulse", qm.size(), 1);
    expect_out("t1", 131072, 30, c1);
    chk("t1_latency", c1, lc + 3);
    chk("t1_err", err, 0);

    // Alternating signs cancel.
    va = '{128, -128, 128, -128, 128, -128, 128, -128};
    vb = '{128, 128, 128, 128, 128, 128, 128, 128};
    send_vec(va, vb, 10, 12, lc);
    idle(6);
    chk("t2a_npulse", qm.size(), 1);
    expect_out("t2a", 0, 22, c1);

    // Largest magnitudes: 8 x 65025.
    va = '{-255, -255, -255, -255, -255, -255, -255, -255};
    vb = va;
    send_vec(va, vb, 3, 4, lc);
    idle(6);
    chk("t2b_npulse", qm.size(), 1);
    expect_out("t2b", 520200, 7, c1);

    // Back-to-back vectors with distinct exponents.
    va = '{128, 128, 128, 128, 128, 128, 128, 128};
    vb = va;
    send_vec(va, vb, 20, 21, lc);
    va = '{-128, -128, -128, -128, -128, -128, -128, -128};
    vb = '{64, 64, 64, 64, 64, 64, 64, 64};
    send_vec(va, vb, 16, 14, lc2);
    idle(8);
    chk("t3_npulse", qm.size(), 2);
    expect_out("t3_v1", 131072, 41, c1);
    expect_out("t3_v2", -65536, 30, c2);
    chk("t3_latency", c1, lc + 3);
    chk("t3_gap", c2 - c1, 4);

    // Valid mismatch on beat 2, ignored beat in ERROR, recovery, clean vector.
    beat(128, 128, 128, 128, 15, 15);
    beat(128, 128, 128, 128, 31, 31);
    beat(128, 128, 128, 128, 31, 31, 1'b1, 1'b0);
    idle(6);
    chk("t4_err", err, 1);
    chk("t4_npulse", qm.size(), 0);
    beat(128, 128, 128, 128, 15, 15);
    idle(2);
    done_pulse();
    va = '{128, 128, 128, 128, 128, 128, 128, 128};
    vb = va;
    send_vec(va, vb, 15, 15, lc);
    idle(6);
    chk("t4_rec_npulse", qm.size(), 1);
    expect_out("t4_rec", 131072, 30, c1);
    chk("t4_err_sticky", err, 1);

    // Asynchronous reset mid-vector, then a fresh vector.
    beat(128, 128, 128, 128, 9, 9);
    beat(128, 128, 128, 128, 31, 31);
    a_valid = 1'b0; b_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_mant", $signed(out_mant), 0);
    chk("t5_rst_exp", out_exp, 0);
    chk("t5_rst_err", err, 0);
    #10;
    reset = 1'b1;
    @(posedge clk); #1;
    va = '{128, 128, 128, 128, 128, 128, 128, 128};
    vb = '{-128, -128, -128, -128, -128, -128, -128, -128};
    send_vec(va, vb, 1, 2, lc);
    idle(6);
    chk("t5_npulse", qm.size(), 1);
    expect_out("t5", -131072, 3, c1);
    chk("t5_err", err, 0);

    // Done in IDLE after a vector is legal; early done mid-vector is not.
    va = '{64, 64, 64, 64, 64, 64, 64, 64};
    vb = va;
    send_vec(va, vb, 7, 8, lc);
    done_pulse();
    idle(6);
    chk("t6_npulse", qm.size(), 1);
    expect_out("t6", 32768, 15, c1);
    chk("t6_idle_done_err", err, 0);
    beat(64, 64, 64, 64, 7, 8);
    beat(64, 64, 64, 64, 31, 31);
    done_pulse();
    idle(6);
    chk("t6_early_err", err, 1);
    chk("t6_early_npulse", qm.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bfp_dot_accum.md
Name: bfp_dot_accum

Overview:
- Downstream consumer of two mantissa-alignment stages, one per operand vector (A and B). Each stage emits P signed block-floating-point mantissas per beat plus the shared block exponent.
- Multiplies lane-wise, reduces the P products, and accumulates V/P beats into one dot-product result.
- Emits the result with the combined block exponent as a one-cycle output pulse.
- Feeds the final normalisation/repack stage.

Parameters:
- V, 8: vector length; multiple of P; NB = V/P beats per vector.
- P, 2: lanes per beat.
- BIT, 16: source float width.
- FPM, 10: source float mantissa width (sets EW = BIT-FPM-1 exponent bits).
- BFPM, 7: BFP mantissa fraction bits; lane width MW = BFPM+2 (sign + hidden 1 + fraction).
- Derived (localparam, not overridable): PW = 2*MW, ACCW = PW + $clog2(V).

Ports:
- clk  in  1  clock; all flops rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- a_valid  in  1  beat valid, operand A.
- a_mants  in  [P-1:0][MW-1:0]  A mantissas, two's complement.
- a_exp  in  EW  A block exponent, biased.
- a_done  in  1  A end-of-vector pulse.
- b_valid, b_mants, b_exp, b_done  in  same widths  operand B equivalents.
- out_valid  out  1  result pulse.
- out_mant  out  ACCW  signed dot product.
- out_exp  out  EW+1  a_exp + b_exp, biased sum, unsigned.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat count=0, all pipeline registers, out_valid, out_mant, out_exp and err = 0. Any partial vector is discarded.
- No backpressure; upstream stages run in lockstep. A beat is accepted when a_valid && b_valid.
- Beat count 0..NB-1. First beat (count=0) latches a_exp+b_exp and tags the beat "first". Beat NB-1 is tagged "last" and the count wraps to 0.
- Exponent inputs are ignored on non-first beats.
- Pipeline:
  - S1 registers P signed products a[i]*b[i], each PW bits, plus first/last tags.
  - S2 reduces the products (sign-extended to ACCW). If tagged first, the accumulator loads the reduced sum; otherwise it adds the sum to the accumulator.
  - When S2 processes a last-tagged beat, the output stage registers out_mant = the final accumulator value and out_exp = the latched exponent, and pulses out_valid for 1 cycle.
- Latency: out_valid is high in the cycle after the 3rd rising edge following the edge that samples the last beat. Exact numbering is fixed by the bench reference model.
- Back-to-back vectors at one beat/cycle with no bubble are supported, because first-tagging restarts the accumulator.
- out_mant and out_exp hold their value until the next out_valid.
- Arithmetic: full-precision signed; no saturation or rounding. ACCW guarantees no overflow for |m| ≤ 2^(MW-1).
- FSM:
  - IDLE: count=0. Accepted beat -> ACCUM (or straight back to IDLE if NB=1).
  - ACCUM: accept beats. Last beat -> IDLE.
  - ERROR: reached from any state on a protocol violation.
- Protocol violations (each sets err=1, discards the partial vector, and suppresses its out_valid):
  - a_valid != b_valid in any cycle.
  - a_done or b_done asserted in ACCUM with count != 0.
  - a_done != b_done.
- In ERROR, inputs are ignored until a cycle with a_done && b_done, then -> IDLE with count=0.
- err is sticky; only reset clears it.
- done pulses in IDLE are legal and ignored, including the done that follows every vector from upstream.
- Simultaneous last beat and done in the same cycle is illegal: treated as early done -> ERROR.

Test Plan:
- V=8, P=2, BFPM=7: 4 beats, all lanes a=b=9'h080 (+128), a_exp=b_exp=15 -> one out_valid, out_mant=131072, out_exp=30.
- a lanes alternating +128/9'h180 (-128), b all +128 -> out_mant=0. Also a=-255, b=-255 on all lanes -> out_mant=520200 (no overflow).
- Two vectors back-to-back with no gap, first sums to 131072, second to -65536 -> two out_valid pulses exactly 4 cycles apart with the correct values. The second vector's exponents 16/14 give out_exp=30, not corrupted by the first vector.
- a_valid=1 with b_valid=0 in the middle of beat 2 -> err=1, no out_valid. Later a_done&&b_done, then a clean vector -> correct result, err still 1.
- reset driven low asynchronously mid-vector (between clock edges) -> outputs 0 immediately. After release, a full new vector -> correct result with no residue from the aborted one.
- Early done after 2 beats -> err=1, no out_valid. Done pulse in IDLE after a normal vector -> no error.
